// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: runs the data-memory req/ack handshake, aligns
// byte lanes, splits misaligned accesses into two word transactions and extends loads.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ByteAccessM,
    input  logic [2:0]        ByteSrcM,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-3:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    localparam int unsigned WA_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        zext_q;
    logic        misal_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] lo_word_q;

    logic        access_c;
    logic [1:0]  off_c;
    logic [2:0]  size_c;
    logic [7:0]  mask_c;
    logic [7:0]  be_img_c;
    logic [63:0] wimg_c;
    logic        misal_c;
    logic [31:0] ld_lo_c;
    logic [31:0] ld_hi_c;
    logic [31:0] ld_word_c;
    logic [31:0] ld_result_c;
    logic        unused_bytesrc;

    // Only bit 2 of ByteSrcM selects the extension; the low bits carry no meaning here.
    assign unused_bytesrc = ^ByteSrcM[1:0];

    assign access_c = MemWriteM | MemReadM;
    assign off_c    = ALUResultM[1:0];

    // Access size decode; the reserved encoding behaves as a word.
    always_comb begin
        size_c = 3'd4;
        mask_c = 8'h0F;
        case (ByteAccessM)
            2'b00: begin
                size_c = 3'd1;
                mask_c = 8'h01;
            end
            2'b01: begin
                size_c = 3'd2;
                mask_c = 8'h03;
            end
            default: begin
                size_c = 3'd4;
                mask_c = 8'h0F;
            end
        endcase
    end

    // Two-word lane images: low halves go to word A, high halves to word A+1.
    assign be_img_c = mask_c << off_c;
    assign wimg_c   = {32'h0, WriteDataM} << {off_c, 3'b000};
    assign misal_c  = (3'(off_c) + size_c) > 3'd4;

    // Load image is assembled from the incoming word plus the captured low word.
    assign ld_lo_c   = (state == REQ_HI) ? lo_word_q : dmem_rdata;
    assign ld_hi_c   = (state == REQ_HI) ? dmem_rdata : 32'h0;
    assign ld_word_c = 32'({ld_hi_c, ld_lo_c} >> {off_q, 3'b000});

    always_comb begin
        ld_result_c = ld_word_c;
        case (size_q)
            3'd1: ld_result_c = zext_q ? {24'h0, ld_word_c[7:0]}
                                       : {{24{ld_word_c[7]}}, ld_word_c[7:0]};
            3'd2: ld_result_c = zext_q ? {16'h0, ld_word_c[15:0]}
                                       : {{16{ld_word_c[15]}}, ld_word_c[15:0]};
            default: ld_result_c = ld_word_c;
        endcase
    end

    // Stall covers the launch cycle and both request phases; DONE lets the pipe advance.
    assign StallM = ~reset & (((state == IDLE) & access_c) |
                              (state == REQ_LO) | (state == REQ_HI));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            ReadDataM  <= 32'h0;
            size_q     <= 3'd0;
            off_q      <= 2'd0;
            zext_q     <= 1'b0;
            misal_q    <= 1'b0;
            be_hi_q    <= 4'h0;
            wdata_hi_q <= 32'h0;
            lo_word_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (access_c) begin
                        state      <= REQ_LO;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWriteM;
                        dmem_addr  <= ALUResultM[ADDR_W-1:2];
                        dmem_be    <= be_img_c[3:0];
                        dmem_wdata <= MemWriteM ? wimg_c[31:0] : 32'h0;
                        be_hi_q    <= be_img_c[7:4];
                        wdata_hi_q <= MemWriteM ? wimg_c[63:32] : 32'h0;
                        size_q     <= size_c;
                        off_q      <= off_c;
                        zext_q     <= ByteSrcM[2];
                        misal_q    <= misal_c;
                    end
                end
                REQ_LO: begin
                    if (dmem_ack) begin
                        lo_word_q <= dmem_rdata;
                        if (misal_q) begin
                            state      <= REQ_HI;
                            dmem_addr  <= dmem_addr + WA_W'(1);
                            dmem_be    <= be_hi_q;
                            dmem_wdata <= wdata_hi_q;
                        end else begin
                            state    <= DONE;
                            dmem_req <= 1'b0;
                            if (!dmem_we) begin
                                ReadDataM <= ld_result_c;
                            end
                        end
                    end
                end
                REQ_HI: begin
                    if (dmem_ack) begin
                        state    <= DONE;
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            ReadDataM <= ld_result_c;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a responder models data memory, a monitor
// checks each presented request and the DONE-cycle load result against queued expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  ByteAccessM;
    logic [2:0]  ByteSrcM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .ByteAccessM(ByteAccessM),
        .ByteSrcM   (ByteSrcM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        last;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int unsigned wait_n;
        logic [31:0] data;
    } resp_t;

    exp_t        exp_q[$];
    resp_t       resp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd_model = 32'h0;
    logic        force_ack = 1'b0;
    logic [31:0] force_data = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [29:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input logic last, input logic [31:0] rd);
        exp_t e;
        e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.last = last; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic push_resp(input int unsigned w, input logic [31:0] d);
        resp_t r;
        r.wait_n = w; r.data = d;
        resp_q.push_back(r);
    endtask

    // Data memory model: each transaction takes wait_n idle cycles then acks with data.
    initial begin : responder
        resp_t       cur;
        bit          busy;
        int unsigned cnt;
        busy = 0;
        cnt = 0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                dmem_ack = 1'b1;
                dmem_rdata = force_data;
            end else if (dmem_req && !reset) begin
                if (!busy) begin
                    if (resp_q.size() > 0) begin
                        cur = resp_q.pop_front();
                    end else begin
                        cur.wait_n = 0;
                        cur.data = 32'h0;
                    end
                    cnt = cur.wait_n;
                    busy = 1;
                end
                if (cnt == 0) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = cur.data;
                    busy = 0;
                end else begin
                    dmem_ack = 1'b0;
                    cnt--;
                end
            end else begin
                dmem_ack = 1'b0;
                if (reset) busy = 0;
            end
        end
    end

    // Monitor: every cycle with a request is compared to the queue head; acks retire it.
    initial begin : monitor
        exp_t        e;
        bit          done_pend;
        logic [31:0] done_rd;
        done_pend = 0;
        done_rd = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                done_pend = 0;
            end else begin
                if (done_pend) begin
                    chk("done_readdata", ReadDataM, done_rd);
                    chk("done_stall", 32'(StallM), 32'h0);
                    done_pend = 0;
                end
                if (dmem_req) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr 0x%08h, required no request", dmem_addr);
                    end else begin
                        e = exp_q[0];
                        chk("req_addr", 32'(dmem_addr), 32'(e.addr));
                        chk("req_we", 32'(dmem_we), 32'(e.we));
                        chk("req_be", 32'(dmem_be), 32'(e.be));
                        if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
                        chk("req_stall", 32'(StallM), 32'h1);
                        if (dmem_ack) begin
                            exp_q.delete(0);
                            if (e.last) begin
                                done_pend = 1;
                                done_rd = e.rd;
                            end
                        end
                    end
                end
            end
        end
    end

    // Presents one M-stage access (entered just after a rising edge) and counts its stall cycles.
    task automatic access(input logic [31:0] a, input logic [1:0] ba, input logic [2:0] bs,
                          input logic mw, input logic mr, input logic [31:0] wd,
                          input int exp_stalls);
        int stalls;
        bit seen_done;
        stalls = 0;
        seen_done = 0;
        ALUResultM = a; ByteAccessM = ba; ByteSrcM = bs;
        MemWriteM = mw; MemReadM = mr; WriteDataM = wd;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (StallM) begin
                stalls++;
            end else begin
                seen_done = 1;
                break;
            end
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: addr 0x%08h still stalled, required completion", a);
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWriteM = 1'b0; MemReadM = 1'b0; ALUResultM = 32'h0;
        WriteDataM = 32'h0; ByteAccessM = 2'b00; ByteSrcM = 3'b000;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit found;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_we", 32'(dmem_we), 32'h0);
        chk("rst_addr", 32'(dmem_addr), 32'h0);
        chk("rst_be", 32'(dmem_be), 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_readdata", ReadDataM, 32'h0);
        chk("rst_stall", 32'(StallM), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_stall", 32'(StallM), 32'h0);

        // Aligned word load
        rd_model = 32'hDEADBEEF;
        push_resp(0, 32'hDEADBEEF);
        push_req(30'h40, 1'b0, 4'b1111, 32'h0, 1'b1, rd_model);
        access(32'h100, 2'b10, 3'b000, 1'b0, 1'b1, 32'h0, 2);

        // Signed and unsigned byte loads from lane 3
        rd_model = 32'hFFFFFF80;
        push_resp(0, 32'h80FF00AA);
        push_req(30'h40, 1'b0, 4'b1000, 32'h0, 1'b1, rd_model);
        access(32'h103, 2'b00, 3'b000, 1'b0, 1'b1, 32'h0, 2);
        rd_model = 32'h00000080;
        push_resp(0, 32'h80FF00AA);
        push_req(30'h40, 1'b0, 4'b1000, 32'h0, 1'b1, rd_model);
        access(32'h103, 2'b00, 3'b100, 1'b0, 1'b1, 32'h0, 2);

        // Halfword store into upper lanes; ReadDataM keeps the last load
        push_resp(0, 32'h0);
        push_req(30'h40, 1'b1, 4'b1100, 32'hBEEF0000, 1'b1, rd_model);
        access(32'h102, 2'b01, 3'b000, 1'b1, 1'b0, 32'h0000BEEF, 2);

        // Misaligned word load
        rd_model = 32'h66778811;
        push_resp(0, 32'h11223344);
        push_resp(0, 32'h55667788);
        push_req(30'h40, 1'b0, 4'b1000, 32'h0, 1'b0, 32'h0);
        push_req(30'h41, 1'b0, 4'b0111, 32'h0, 1'b1, rd_model);
        access(32'h103, 2'b10, 3'b000, 1'b0, 1'b1, 32'h0, 3);

        // Misaligned signed halfword load spanning words
        rd_model = 32'hFFFFF011;
        push_resp(0, 32'h11223344);
        push_resp(0, 32'h000000F0);
        push_req(30'h40, 1'b0, 4'b1000, 32'h0, 1'b0, 32'h0);
        push_req(30'h41, 1'b0, 4'b0001, 32'h0, 1'b1, rd_model);
        access(32'h103, 2'b01, 3'b000, 1'b0, 1'b1, 32'h0, 3);

        // Misaligned word store with three wait cycles per transaction
        push_resp(3, 32'h0);
        push_resp(3, 32'h0);
        push_req(30'h1F, 1'b1, 4'b1100, 32'hCCDD0000, 1'b0, 32'h0);
        push_req(30'h20, 1'b1, 4'b0011, 32'h0000AABB, 1'b1, rd_model);
        access(32'h7E, 2'b10, 3'b000, 1'b1, 1'b0, 32'hAABBCCDD, 9);

        // Store and load both asserted: the store wins
        push_resp(0, 32'hFFFFFFFF);
        push_req(30'h80, 1'b1, 4'b1111, 32'h12345678, 1'b1, rd_model);
        access(32'h200, 2'b10, 3'b000, 1'b1, 1'b1, 32'h12345678, 2);

        // Misaligned load at the top of memory wraps to word 0
        rd_model = 32'h11AABBCC;
        push_resp(0, 32'hAABBCCDD);
        push_resp(0, 32'h00000011);
        push_req(30'h3FFFFFFF, 1'b0, 4'b1110, 32'h0, 1'b0, 32'h0);
        push_req(30'h0, 1'b0, 4'b0001, 32'h0, 1'b1, rd_model);
        access(32'hFFFFFFFD, 2'b10, 3'b000, 1'b0, 1'b1, 32'h0, 3);

        idle_inputs();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("gap_stall", 32'(StallM), 32'h0);
            chk("gap_req", 32'(dmem_req), 32'h0);
        end
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        // Reset in REQ_HI: outputs clear immediately and a late ack is ignored
        push_resp(0, 32'h01020304);
        push_resp(1000, 32'h0);
        push_req(30'h40, 1'b0, 4'b1000, 32'h0, 1'b0, 32'h0);
        push_req(30'h41, 1'b0, 4'b0111, 32'h0, 1'b1, rd_model);
        @(posedge clk);
        #1;
        ALUResultM = 32'h103; ByteAccessM = 2'b10; ByteSrcM = 3'b000;
        MemReadM = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (dmem_req && dmem_addr == 30'h41) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL reach_req_hi: addr 0x%08h, required a request to 0x41", dmem_addr);
        end
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'h0);
        chk("midrst_we", 32'(dmem_we), 32'h0);
        chk("midrst_addr", 32'(dmem_addr), 32'h0);
        chk("midrst_be", 32'(dmem_be), 32'h0);
        chk("midrst_wdata", dmem_wdata, 32'h0);
        chk("midrst_readdata", ReadDataM, 32'h0);
        chk("midrst_stall", 32'(StallM), 32'h0);
        exp_q.delete();
        resp_q.delete();
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        force_data = 32'hFFFFFFFF;
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("late_ack_req", 32'(dmem_req), 32'h0);
            chk("late_ack_stall", 32'(StallM), 32'h0);
            chk("late_ack_readdata", ReadDataM, 32'h0);
        end
        force_ack = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
